// File: rtl/fc_seq_mac.sv
// Time-multiplexed fully-connected classifier: PAR_MACS lanes accumulate class scores,
// then bias/ReLU/saturation and a sequential strict-greater argmax.
//   state     | meaning
//   ST_IDLE   | waiting for en; clears accumulators on start
//   ST_MAC    | one input element x lane group per cycle
//   ST_POST   | bias, ReLU, saturation into o_featuremap
//   ST_ARGMAX | one class compared per cycle
//   ST_DONE   | result valid until en seen low
module fc_seq_mac #(
    parameter int STARTING_SIZE       = 2,
    parameter int CHANNELS            = 2,
    parameter int ELEMENT_SIZE        = 20,
    parameter int WEIGHT_DEPTH        = 8,
    parameter int BIAS_SIZE           = 16,
    parameter int CLASSIFICATIONS     = 10,
    parameter int ENDING_ELEMENT_SIZE = 30,
    parameter int PAR_MACS            = 2,
    parameter int SIGNED              = 0,
    parameter int RELU                = 0
) (
    input  logic                                                                      clk,
    input  logic                                                                      rst,
    input  logic                                                                      en,
    input  logic [STARTING_SIZE*STARTING_SIZE*CHANNELS*ELEMENT_SIZE-1:0]              i_featuremap,
    input  logic [STARTING_SIZE*STARTING_SIZE*CHANNELS*CLASSIFICATIONS*WEIGHT_DEPTH-1:0] weights,
    input  logic [CLASSIFICATIONS*BIAS_SIZE-1:0]                                      bias,
    output logic [CLASSIFICATIONS*ENDING_ELEMENT_SIZE-1:0]                            o_featuremap,
    output logic [$clog2(CLASSIFICATIONS)-1:0]                                        o_class,
    output logic                                                                      busy,
    output logic                                                                      done
);
    localparam int N_IN   = STARTING_SIZE * STARTING_SIZE * CHANNELS;
    localparam int GROUPS = (CLASSIFICATIONS + PAR_MACS - 1) / PAR_MACS;
    localparam int EO     = ENDING_ELEMENT_SIZE;
    localparam int ACC_W  = ELEMENT_SIZE + WEIGHT_DEPTH + $clog2(N_IN) + 1;
    localparam int SUM_W  = ((ACC_W > BIAS_SIZE) ? ACC_W : BIAS_SIZE) + 1;
    localparam int LIM_W  = ((SUM_W > EO) ? SUM_W : EO + 1) + 1;
    localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW     = $clog2(CLASSIFICATIONS);

    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [CW-1:0] A_LAST = CW'(CLASSIFICATIONS - 1);

    localparam logic [LIM_W-1:0] ONE_L = LIM_W'(1);
    localparam logic signed [LIM_W-1:0] SAT_HI = (SIGNED != 0) ? signed'((ONE_L << (EO - 1)) - ONE_L)
                                                               : signed'((ONE_L << EO) - ONE_L);
    localparam logic signed [LIM_W-1:0] SAT_LO = (SIGNED != 0) ? signed'(~(ONE_L << (EO - 1)) + ONE_L)
                                                               : '0;

    typedef enum logic [2:0] {ST_IDLE, ST_MAC, ST_POST, ST_ARGMAX, ST_DONE} state_t;
    state_t state, next_state;

    logic [IW-1:0]           idx_i;
    logic [GW-1:0]           idx_g;
    logic [CW-1:0]           arg_idx;
    logic [CW-1:0]           best_idx;
    logic signed [EO:0]      best_val;
    logic signed [EO:0]      arg_cur;
    logic                    arg_take;
    logic                    mac_last;
    logic signed [ACC_W-1:0] acc [CLASSIFICATIONS];
    logic signed [ACC_W-1:0] lane_prod [PAR_MACS];
    int                      lane_k [PAR_MACS];
    logic                    lane_valid [PAR_MACS];

    function automatic logic signed [ACC_W-1:0] ext_x(input logic [ELEMENT_SIZE-1:0] v);
        return (SIGNED != 0) ? {{(ACC_W-ELEMENT_SIZE){v[ELEMENT_SIZE-1]}}, v}
                             : {{(ACC_W-ELEMENT_SIZE){1'b0}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] ext_w(input logic [WEIGHT_DEPTH-1:0] v);
        return (SIGNED != 0) ? {{(ACC_W-WEIGHT_DEPTH){v[WEIGHT_DEPTH-1]}}, v}
                             : {{(ACC_W-WEIGHT_DEPTH){1'b0}}, v};
    endfunction

    function automatic logic signed [EO:0] ext_s(input logic [EO-1:0] v);
        return (SIGNED != 0) ? {v[EO-1], v} : {1'b0, v};
    endfunction

    // ReLU sees the biased sum; saturation is done in a width that holds both the sum and the limits.
    function automatic logic [EO-1:0] post_fn(input logic signed [ACC_W-1:0] a,
                                              input logic [BIAS_SIZE-1:0] b);
        logic signed [SUM_W-1:0] s;
        logic signed [LIM_W-1:0] l;
        s = {{(SUM_W-ACC_W){a[ACC_W-1]}}, a}
          + ((SIGNED != 0) ? {{(SUM_W-BIAS_SIZE){b[BIAS_SIZE-1]}}, b}
                           : {{(SUM_W-BIAS_SIZE){1'b0}}, b});
        if (RELU != 0 && SIGNED != 0 && s < 0) s = '0;
        l = {{(LIM_W-SUM_W){s[SUM_W-1]}}, s};
        if (l > SAT_HI) return SAT_HI[EO-1:0];
        if (l < SAT_LO) return SAT_LO[EO-1:0];
        return l[EO-1:0];
    endfunction

    always_comb begin
        for (int p = 0; p < PAR_MACS; p++) begin
            lane_k[p]     = int'(idx_g) * PAR_MACS + p;
            lane_valid[p] = lane_k[p] < CLASSIFICATIONS;
            lane_prod[p]  = '0;
            if (lane_valid[p])
                lane_prod[p] = ext_x(i_featuremap[int'(idx_i)*ELEMENT_SIZE +: ELEMENT_SIZE])
                             * ext_w(weights[(int'(idx_i)*CLASSIFICATIONS + lane_k[p])*WEIGHT_DEPTH +: WEIGHT_DEPTH]);
        end
    end

    assign mac_last = (idx_i == I_LAST) && (idx_g == G_LAST);
    assign arg_cur  = ext_s(o_featuremap[int'(arg_idx)*EO +: EO]);
    assign arg_take = (arg_idx == '0) || (arg_cur > best_val);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE:   if (en) next_state = ST_MAC;
            ST_MAC: begin
                busy = 1'b1;
                if (mac_last) next_state = ST_POST;
            end
            ST_POST: begin
                busy       = 1'b1;
                next_state = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                busy = 1'b1;
                if (arg_idx == A_LAST) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!en) next_state = ST_IDLE;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CLASSIFICATIONS; k++) acc[k] <= '0;
            idx_i        <= '0;
            idx_g        <= '0;
            arg_idx      <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            o_featuremap <= '0;
            o_class      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        for (int k = 0; k < CLASSIFICATIONS; k++) acc[k] <= '0;
                        idx_i <= '0;
                        idx_g <= '0;
                    end
                end
                ST_MAC: begin
                    for (int p = 0; p < PAR_MACS; p++)
                        if (lane_valid[p]) acc[lane_k[p]] <= acc[lane_k[p]] + lane_prod[p];
                    if (idx_i == I_LAST) begin
                        idx_i <= '0;
                        idx_g <= idx_g + GW'(1);
                    end else begin
                        idx_i <= idx_i + IW'(1);
                    end
                end
                ST_POST: begin
                    for (int k = 0; k < CLASSIFICATIONS; k++)
                        o_featuremap[k*EO +: EO] <= post_fn(acc[k], bias[k*BIAS_SIZE +: BIAS_SIZE]);
                    arg_idx <= '0;
                end
                ST_ARGMAX: begin
                    if (arg_take) begin
                        best_val <= arg_cur;
                        best_idx <= arg_idx;
                    end
                    if (arg_idx == A_LAST) o_class <= arg_take ? arg_idx : best_idx;
                    arg_idx <= arg_idx + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_seq_mac.sv
// Bench for fc_seq_mac: five parameterisations checked against an arithmetic reference model
// with directed cases, handshake/reset scenarios and randomized data.
module tb_fc_seq_mac;
    localparam int NX = 8;
    localparam int NC = 10;
    localparam int LAT [5] = '{52, 44, 20, 52, 32};
    localparam int SGN [5] = '{1, 1, 1, 0, 0};
    localparam int RLU [5] = '{1, 1, 1, 0, 0};
    localparam int EOW [5] = '{30, 30, 30, 16, 30};
    localparam int NIN [5] = '{8, 8, 8, 8, 4};

    logic clk = 1'b0;
    logic rst;
    logic [4:0] en_v;
    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic [NX*20-1:0]    fm8;
    logic [NX*NC*8-1:0]  w8;
    logic [NC*16-1:0]    bvec;
    logic [4*20-1:0]     fm4;
    logic [4*NC*8-1:0]   w4;
    logic [NC*30-1:0]    of_a, of_b, of_c, of_e;
    logic [NC*16-1:0]    of_d;
    logic [3:0]          oc_a, oc_b, oc_c, oc_d, oc_e;

    longint xv [NX];
    longint wv [NX][NC];
    longint bv [NC];
    longint exp_score [NC];
    int     exp_class;
    int     errors;
    int     checks;

    always #5 clk = ~clk;

    fc_seq_mac #(.SIGNED(1), .RELU(1)) u_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .i_featuremap(fm8), .weights(w8), .bias(bvec),
        .o_featuremap(of_a), .o_class(oc_a), .busy(busy_v[0]), .done(done_v[0]));
    fc_seq_mac #(.PAR_MACS(3), .SIGNED(1), .RELU(1)) u_b (
        .clk(clk), .rst(rst), .en(en_v[1]), .i_featuremap(fm8), .weights(w8), .bias(bvec),
        .o_featuremap(of_b), .o_class(oc_b), .busy(busy_v[1]), .done(done_v[1]));
    fc_seq_mac #(.PAR_MACS(10), .SIGNED(1), .RELU(1)) u_c (
        .clk(clk), .rst(rst), .en(en_v[2]), .i_featuremap(fm8), .weights(w8), .bias(bvec),
        .o_featuremap(of_c), .o_class(oc_c), .busy(busy_v[2]), .done(done_v[2]));
    fc_seq_mac #(.ENDING_ELEMENT_SIZE(16)) u_d (
        .clk(clk), .rst(rst), .en(en_v[3]), .i_featuremap(fm8), .weights(w8), .bias(bvec),
        .o_featuremap(of_d), .o_class(oc_d), .busy(busy_v[3]), .done(done_v[3]));
    fc_seq_mac #(.CHANNELS(1)) u_e (
        .clk(clk), .rst(rst), .en(en_v[4]), .i_featuremap(fm4), .weights(w4), .bias(bvec),
        .o_featuremap(of_e), .o_class(oc_e), .busy(busy_v[4]), .done(done_v[4]));

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint sx(input longint raw, input int bits, input int sgn);
        if (sgn != 0 && raw >= (longint'(1) << (bits - 1))) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    function automatic void model(input int id);
        longint s, hi, lo;
        hi = (SGN[id] != 0) ? (longint'(1) << (EOW[id] - 1)) - 1 : (longint'(1) << EOW[id]) - 1;
        lo = (SGN[id] != 0) ? -(longint'(1) << (EOW[id] - 1)) : 0;
        exp_class = 0;
        for (int k = 0; k < NC; k++) begin
            s = sx(bv[k], 16, SGN[id]);
            for (int i = 0; i < NIN[id]; i++)
                s += sx(xv[i], 20, SGN[id]) * sx(wv[i][k], 8, SGN[id]);
            if (RLU[id] != 0 && s < 0) s = 0;
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            exp_score[k] = s;
            if (k > 0 && s > exp_score[exp_class]) exp_class = k;
        end
    endfunction

    function automatic void pack();
        for (int i = 0; i < NX; i++) begin
            fm8[i*20 +: 20] = 20'(xv[i]);
            if (i < 4) fm4[i*20 +: 20] = 20'(xv[i]);
            for (int k = 0; k < NC; k++) begin
                w8[(i*NC+k)*8 +: 8] = 8'(wv[i][k]);
                if (i < 4) w4[(i*NC+k)*8 +: 8] = 8'(wv[i][k]);
            end
        end
        for (int k = 0; k < NC; k++) bvec[k*16 +: 16] = 16'(bv[k]);
    endfunction

    function automatic longint score_of(input int id, input int k);
        case (id)
            0:       return longint'(of_a[k*30 +: 30]);
            1:       return longint'(of_b[k*30 +: 30]);
            2:       return longint'(of_c[k*30 +: 30]);
            3:       return longint'(of_d[k*16 +: 16]);
            default: return longint'(of_e[k*30 +: 30]);
        endcase
    endfunction

    function automatic longint class_of(input int id);
        case (id)
            0:       return longint'(oc_a);
            1:       return longint'(oc_b);
            2:       return longint'(oc_c);
            3:       return longint'(oc_d);
            default: return longint'(oc_e);
        endcase
    endfunction

    // mode 0: en held through done; 1: en pulsed one cycle; 2: en toggled during the run
    task automatic run(input int id, input int lat, input int mode, input string tag);
        int n;
        longint mask;
        model(id);
        mask = (longint'(1) << EOW[id]) - 1;
        @(negedge clk);
        en_v[id] = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (done_v[id]) break;
            if (mode == 1) en_v[id] = 1'b0;
            if (mode == 2) en_v[id] = (n < 30) ? n[0] : 1'b1;
        end
        chk({tag, "_latency"}, longint'(n), longint'(lat));
        chk({tag, "_busy_at_done"}, longint'(busy_v[id]), 0);
        for (int k = 0; k < NC; k++)
            chk($sformatf("%s_score%0d", tag, k), score_of(id, k), exp_score[k] & mask);
        chk({tag, "_class"}, class_of(id), longint'(exp_class));
        if (mode == 1) begin
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, longint'(done_v[id]), 0);
        end else begin
            repeat (3) @(negedge clk);
            chk({tag, "_done_held"}, longint'(done_v[id]), 1);
            en_v[id] = 1'b0;
            @(negedge clk);
            chk({tag, "_done_drop"}, longint'(done_v[id]), 0);
            chk({tag, "_idle_busy"}, longint'(busy_v[id]), 0);
        end
    endtask

    task automatic set_t1();
        for (int i = 0; i < NX; i++)
            for (int k = 0; k < NC; k++) begin
                xv[i]    = (i < 4) ? longint'((i / 2) * 100 + (i % 2) * 25) : 0;
                wv[i][k] = (i < 4) ? longint'(((i / 2) * 150 + (i % 2) * 20 + k * 5) % 256) : 0;
            end
        for (int k = 0; k < NC; k++) bv[k] = 0;
    endtask

    task automatic set_t2();
        for (int i = 0; i < NX; i++) begin
            xv[i] = (longint'(1) << 20) - 3;
            for (int k = 0; k < NC; k++) wv[i][k] = 2;
        end
        for (int k = 0; k < NC; k++) bv[k] = 10 * k;
    endtask

    task automatic set_t3();
        for (int i = 0; i < NX; i++) begin
            xv[i] = 64'hFFFFF;
            for (int k = 0; k < NC; k++) wv[i][k] = 255;
        end
        for (int k = 0; k < NC; k++) bv[k] = 0;
    endtask

    task automatic set_rand(input int big);
        int t;
        for (int i = 0; i < NX; i++) begin
            t = int'($urandom_range(0, 200)) - 100;
            xv[i] = (big != 0) ? longint'($urandom_range(0, 20'hFFFFF)) : (longint'(t) & 64'hFFFFF);
            for (int k = 0; k < NC; k++) wv[i][k] = longint'($urandom_range(0, 255));
        end
        for (int k = 0; k < NC; k++) begin
            t = int'($urandom_range(0, 2000)) - 1000;
            bv[k] = (big != 0) ? longint'($urandom_range(0, 16'hFFFF)) : (longint'(t) & 64'hFFFF);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        en_v   = '0;
        set_t3();
        pack();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 5; id++) begin
            chk($sformatf("reset_busy%0d", id), longint'(busy_v[id]), 0);
            chk($sformatf("reset_done%0d", id), longint'(done_v[id]), 0);
            chk($sformatf("reset_class%0d", id), class_of(id), 0);
            chk($sformatf("reset_score%0d", id), score_of(id, NC - 1), 0);
        end
        rst = 1'b0;

        set_t1();
        pack();
        run(4, 32, 0, "t1");
        chk("t1_spec_k0", score_of(4, 0), 36750);
        chk("t1_spec_k9", score_of(4, 9), 48000);
        chk("t1_spec_class", class_of(4), 9);

        set_t2();
        pack();
        run(0, 52, 0, "t2");
        chk("t2_spec_k0", score_of(0, 0), 0);
        chk("t2_spec_k5", score_of(0, 5), 2);
        chk("t2_spec_k9", score_of(0, 9), 42);
        chk("t2_spec_class", class_of(0), 9);
        run(1, 44, 0, "t6_p3");
        chk("t6_p3_spec_k9", score_of(1, 9), 42);
        run(2, 20, 0, "t6_p10");
        chk("t6_p10_spec_k5", score_of(2, 5), 2);
        run(0, 52, 1, "t4_pulse");
        run(0, 52, 2, "t4_toggle");

        set_t3();
        pack();
        run(3, 52, 0, "t3");
        chk("t3_spec_k4", score_of(3, 4), 64'hFFFF);
        chk("t3_spec_class", class_of(3), 0);

        set_t2();
        pack();
        @(negedge clk);
        en_v[0] = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        chk("t5_busy_before", longint'(busy_v[0]), 1);
        rst     = 1'b1;
        en_v[0] = 1'b0;
        @(negedge clk);
        chk("t5_busy", longint'(busy_v[0]), 0);
        chk("t5_done", longint'(done_v[0]), 0);
        chk("t5_scores_zero", longint'(of_a != '0), 0);
        chk("t5_class", longint'(oc_a), 0);
        rst = 1'b0;
        run(0, 52, 0, "t5_restart");

        for (int r = 0; r < 4; r++) begin
            for (int id = 0; id < 5; id++) begin
                set_rand(r % 2);
                pack();
                run(id, LAT[id], r % 3, $sformatf("rnd%0d_%0d", r, id));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
